load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: DM_WORDS, 64, number of 32-bit words in the data memory; used for range check.
REQ-002 SHALL have one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-003 clk  input  1  rising-edge clock shared with data memory.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  MEM-stage instruction is a load or store.
REQ-006 mem_write  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address from ALU.
REQ-009 store_data  input  32  rs2 value; low bits used for SB/SH.
REQ-010 load_data  output  32  extended load result to MEM/WB.
REQ-011 load_valid  output  1  load_data valid this cycle.
REQ-012 stall  output  1  hold IF..MEM stages this cycle.
REQ-013 misaligned  output  1  address not aligned to access width.
REQ-014 out_of_range  output  1  addr[31:2] >= DM_WORDS.
REQ-015 dm_we, dm_addr[31:0], dm_wd[31:0]  output  -  write enable, address, write data to data memory.
REQ-016 dm_rd  input  32  combinational read data from data memory.

Function
REQ-017 SHALL implement FSM states IDLE and RMW_WR.
REQ-018 Loads (IDLE, aligned, in range, legal funct3): dm_addr=addr; load_data from dm_rd in the same cycle; load_valid=1; no stall.
REQ-019 Load extension:
- LB/LH sign-extend the selected byte/half.
- LBU/LHU zero-extend it.
- Byte lane = addr[1:0]; half lane = addr[1].
REQ-020 SW (aligned): dm_we=1 and dm_wd=store_data in the same cycle; stays in IDLE; no stall.
REQ-021 SB/SH, IDLE cycle:
- dm_we=0; stall=1.
- Merge store_data[7:0]/[15:0] into dm_rd at the addressed lane.
- Register merged word and word address; go to RMW_WR.
REQ-022 RMW_WR cycle: dm_we=1, dm_addr=latched address, dm_wd=latched merged word, stall=0; return to IDLE next edge.
REQ-023 In RMW_WR, addr/store_data/funct3 inputs SHALL be ignored; only latched values are used.
REQ-024 Misaligned access (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0):
- misaligned=1; dm_we=0; load_valid=0; load_data=0; no stall; no state change.
REQ-025 Out-of-range access: out_of_range=1 with the same suppression as REQ-024; both flags may assert together.
REQ-026 Illegal funct3 (011, 110, 111): no write, load_valid=0, load_data=0, flags 0.
REQ-027 req_valid=0 in IDLE: dm_we=0, load_valid=0, stall=0, load_data=0.
REQ-028 Stores SHALL never assert load_valid; loads SHALL never assert dm_we.

Reset
REQ-029 Reset SHALL force IDLE and clear the latched address and merged word to 0.
REQ-030 Reset asserted in RMW_WR SHALL drop the pending write (dm_we=0 while reset is high).
REQ-031 During reset: stall=0, load_valid=0, misaligned=0, out_of_range=0.

Structure
REQ-032 Package lsu_pkg SHALL hold funct3 width constants and the FSM state enum.
REQ-033 Sub-module lsu_store_merge (combinational lane merge for SB/SH) SHALL be instantiated once; load extension stays in load_store_unit.

Verification
REQ-034 SW addr=0x08, data=0xDEADBEEF -> dm_we=1 same cycle, no stall; following LW 0x08 -> load_data=0xDEADBEEF.
REQ-035 Word 0x08 holds 0xDEADBEEF; SB addr=0x09, data=0x55 -> cycle 1 stall=1, dm_we=0; cycle 2 dm_we=1, dm_wd=0xDEAD55EF.
REQ-036 Word 0x08 holds 0xDEAD55EF; LB 0x0B -> 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x08 -> 0x000055EF.
REQ-037 LW 0x06 -> misaligned=1, load_valid=0; SH 0x03 -> misaligned=1, no write, no stall.
REQ-038 SW addr=0x100 with DM_WORDS=64 -> out_of_range=1, dm_we=0.
REQ-039 SH 0x0A, reset asserted during RMW_WR -> no write; word 0x08 unchanged; state IDLE after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes and FSM state.
// No logic of its own; legality helper is purely combinational.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    // Stores only have signed widths; the unsigned codes are load-only.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_store_merge.sv
// Lane merge for sub-word stores: replaces one byte or half of a read word.
// Purely combinational, zero latency; no flow control.
module lsu_store_merge (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic        half,
    output logic [31:0] merged
);

    always_comb begin
        merged = word;
        if (half) begin
            if (lane[1])
                merged[31:16] = wdata[15:0];
            else
                merged[15:0]  = wdata[15:0];
        end else begin
            case (lane)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: loads and SW complete combinationally in one cycle,
// SB/SH take a read-modify-write over two cycles, stalling the pipe for the first.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    localparam logic [29:0] DM_LIMIT = 30'(DM_WORDS);

    lsu_state_t  state;
    logic [31:0] rmw_addr;
    logic [31:0] rmw_word;
    logic [31:0] merged;

    logic is_h, is_w, legal, mis_c, oor_c, req, ok, rmw_start;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;

    assign is_h  = (funct3[1:0] == 2'b01);
    assign is_w  = (funct3 == F3_W);
    assign legal = f3_legal(mem_write, funct3);
    assign mis_c = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
    assign oor_c = (addr[31:2] >= DM_LIMIT);

    // Requests are only decoded in IDLE; RMW_WR works purely from latched state.
    assign req       = req_valid && !reset && (state == IDLE) && legal;
    assign ok        = req && !mis_c && !oor_c;
    assign rmw_start = ok && mem_write && !is_w;

    lsu_store_merge u_merge (
        .word   (dm_rd),
        .wdata  (store_data),
        .lane   (addr[1:0]),
        .half   (is_h),
        .merged (merged)
    );

    always_comb begin
        byte_sel = 8'h00;
        case (addr[1:0])
            2'd0:    byte_sel = dm_rd[7:0];
            2'd1:    byte_sel = dm_rd[15:8];
            2'd2:    byte_sel = dm_rd[23:16];
            default: byte_sel = dm_rd[31:24];
        endcase
        half_sel = addr[1] ? dm_rd[31:16] : dm_rd[15:0];
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_W:    ext = dm_rd;
            F3_BU:   ext = {24'h0, byte_sel};
            F3_HU:   ext = {16'h0, half_sel};
            default: ext = 32'h0;
        endcase
    end

    always_comb begin
        misaligned   = req && mis_c;
        out_of_range = req && oor_c;
        load_valid   = ok && !mem_write;
        load_data    = load_valid ? ext : 32'h0;
        stall        = rmw_start;
        if (state == RMW_WR) begin
            dm_we   = !reset;
            dm_addr = rmw_addr;
            dm_wd   = rmw_word;
        end else begin
            dm_we   = ok && mem_write && is_w;
            dm_addr = addr;
            dm_wd   = store_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rmw_addr <= 32'h0;
            rmw_word <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (rmw_start) begin
                        state    <= RMW_WR;
                        rmw_addr <= {addr[31:2], 2'b00};
                        rmw_word <= merged;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
